// File: rtl/sc_level_tracker_pkg.sv
// Shared definitions for the Frogger level/progress tracker: FSM state encoding
// and the saturating accumulator helper used by the optional score feature.
package sc_level_tracker_pkg;

    localparam int STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE       = 2'b00,
        PLAY       = 2'b01,
        LEVEL_DONE = 2'b10,
        WON        = 2'b11
    } trackerState_e;

    // Operands are zero-extended by the caller; the result is clamped at maxVal.
    function automatic logic [31:0] satAdd(input logic [31:0] acc,
                                           input logic [31:0] inc,
                                           input logic [31:0] maxVal);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum > {1'b0, maxVal}) ? maxVal : sum[31:0];
    endfunction

endpackage

// File: rtl/sc_level_tracker_edge.sv
// Registered-history edge detector with selectable polarity and reset value of the
// history register; the event is combinational from history and the live input.
module sc_level_tracker_edge #(
    parameter bit FALLING   = 1'b1,
    parameter bit RESET_VAL = 1'b1
) (
    input  logic SC_LEVELTRACKEREDGE_CLOCK_50,
    input  logic SC_LEVELTRACKEREDGE_RESET_InHigh,
    input  logic SC_LEVELTRACKEREDGE_Signal_in,
    output logic SC_LEVELTRACKEREDGE_Event_out
);

    logic hist;

    always_ff @(posedge SC_LEVELTRACKEREDGE_CLOCK_50) begin
        if (SC_LEVELTRACKEREDGE_RESET_InHigh) begin
            hist <= RESET_VAL;
        end else begin
            hist <= SC_LEVELTRACKEREDGE_Signal_in;
        end
    end

    assign SC_LEVELTRACKEREDGE_Event_out = FALLING ? (hist & ~SC_LEVELTRACKEREDGE_Signal_in)
                                                   : (~hist & SC_LEVELTRACKEREDGE_Signal_in);

endmodule

// File: rtl/sc_level_tracker.sv
// Frogger level/progress tracker: counts goals per level, advances levels, flags the win.
// Optional score accumulator enabled by defining SC_LEVELTRACKER_SCORE_EN.
module sc_level_tracker
    import sc_level_tracker_pkg::*;
#(
    parameter int PROGRESS_WIDTH  = 5,
    parameter int LEVEL_WIDTH     = 3,
    parameter int GOALS_PER_LEVEL = 5,
    parameter int NUM_LEVELS      = 4,
    parameter int SCORE_WIDTH     = 16
) (
    input  logic                      SC_LEVELTRACKER_CLOCK_50,
    input  logic                      SC_LEVELTRACKER_RESET_InHigh,
    input  logic                      SC_LEVELTRACKER_Start_in,
    input  logic                      SC_LEVELTRACKER_Goal_InLow,
    input  logic                      SC_LEVELTRACKER_ClearProgress_in,
    input  logic                      SC_LEVELTRACKER_Abort_in,
    output logic [PROGRESS_WIDTH-1:0] SC_LEVELTRACKER_Progress_OutBus,
    output logic [LEVEL_WIDTH-1:0]    SC_LEVELTRACKER_Level_OutBus,
    output logic                      SC_LEVELTRACKER_LevelUp_out,
    output logic                      SC_LEVELTRACKER_GameWon_out,
    output logic [STATE_WIDTH-1:0]    SC_LEVELTRACKER_State_OutBus
`ifdef SC_LEVELTRACKER_SCORE_EN
    ,
    output logic [SCORE_WIDTH-1:0]    SC_LEVELTRACKER_Score_OutBus
`endif
);

    localparam logic [PROGRESS_WIDTH-1:0] LAST_GOAL  = PROGRESS_WIDTH'(GOALS_PER_LEVEL - 1);
    localparam logic [LEVEL_WIDTH-1:0]    LAST_LEVEL = LEVEL_WIDTH'(NUM_LEVELS - 1);

    trackerState_e             state, stateNext;
    logic [PROGRESS_WIDTH-1:0] progress, progressNext;
    logic [LEVEL_WIDTH-1:0]    level, levelNext;
    logic                      goalEvt;
    logic                      goalAccepted;
    logic                      scoreClear;

    sc_level_tracker_edge #(
        .FALLING   (1'b1),
        .RESET_VAL (1'b1)
    ) uGoalEdge (
        .SC_LEVELTRACKEREDGE_CLOCK_50    (SC_LEVELTRACKER_CLOCK_50),
        .SC_LEVELTRACKEREDGE_RESET_InHigh(SC_LEVELTRACKER_RESET_InHigh),
        .SC_LEVELTRACKEREDGE_Signal_in   (SC_LEVELTRACKER_Goal_InLow),
        .SC_LEVELTRACKEREDGE_Event_out   (goalEvt)
    );

    always_ff @(posedge SC_LEVELTRACKER_CLOCK_50) begin
        if (SC_LEVELTRACKER_RESET_InHigh) begin
            state    <= IDLE;
            progress <= '0;
            level    <= '0;
        end else begin
            state    <= stateNext;
            progress <= progressNext;
            level    <= levelNext;
        end
    end

    always_comb begin
        stateNext    = state;
        progressNext = progress;
        levelNext    = level;
        goalAccepted = 1'b0;
        scoreClear   = 1'b0;
        case (state)
            IDLE: begin
                progressNext = '0;
                levelNext    = '0;
                if (SC_LEVELTRACKER_Start_in) begin
                    stateNext  = PLAY;
                    scoreClear = 1'b1;
                end
            end
            PLAY: begin
                if (SC_LEVELTRACKER_Abort_in) begin
                    stateNext    = IDLE;
                    progressNext = '0;
                    levelNext    = '0;
                    scoreClear   = 1'b1;
                end else if (SC_LEVELTRACKER_ClearProgress_in) begin
                    progressNext = '0;
                end else if (goalEvt) begin
                    goalAccepted = 1'b1;
                    if (progress >= LAST_GOAL) begin
                        progressNext = '0;
                        stateNext    = LEVEL_DONE;
                    end else begin
                        progressNext = progress + PROGRESS_WIDTH'(1);
                    end
                end
            end
            LEVEL_DONE: begin
                if (SC_LEVELTRACKER_Abort_in) begin
                    stateNext    = IDLE;
                    progressNext = '0;
                    levelNext    = '0;
                    scoreClear   = 1'b1;
                end else if (level == LAST_LEVEL) begin
                    stateNext = WON;
                end else begin
                    levelNext = level + LEVEL_WIDTH'(1);
                    stateNext = PLAY;
                end
            end
            WON: begin
                progressNext = '0;
                levelNext    = LAST_LEVEL;
                // Abort outranks a simultaneous restart.
                if (SC_LEVELTRACKER_Abort_in) begin
                    stateNext  = IDLE;
                    levelNext  = '0;
                    scoreClear = 1'b1;
                end else if (SC_LEVELTRACKER_Start_in) begin
                    stateNext  = PLAY;
                    levelNext  = '0;
                    scoreClear = 1'b1;
                end
            end
            default: begin
                stateNext    = IDLE;
                progressNext = '0;
                levelNext    = '0;
            end
        endcase
    end

    assign SC_LEVELTRACKER_Progress_OutBus = progress;
    assign SC_LEVELTRACKER_Level_OutBus    = level;
    assign SC_LEVELTRACKER_LevelUp_out     = (state == LEVEL_DONE);
    assign SC_LEVELTRACKER_GameWon_out     = (state == WON);
    assign SC_LEVELTRACKER_State_OutBus    = state;

`ifdef SC_LEVELTRACKER_SCORE_EN
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    logic [SCORE_WIDTH-1:0] score;

    // The final goal of a level scores with the level index before it advances.
    always_ff @(posedge SC_LEVELTRACKER_CLOCK_50) begin
        if (SC_LEVELTRACKER_RESET_InHigh || scoreClear) begin
            score <= '0;
        end else if (goalAccepted) begin
            score <= SCORE_WIDTH'(satAdd(32'(score), 32'(level) + 32'd1, 32'(SCORE_MAX)));
        end
    end

    assign SC_LEVELTRACKER_Score_OutBus = score;
`else
    logic unusedScore;
    assign unusedScore = ^{goalAccepted, scoreClear, 32'(SCORE_WIDTH)};
`endif

endmodule

// File: tb/tb_sc_level_tracker.sv
// Directed bench for sc_level_tracker; the score test is built only when
// SC_LEVELTRACKER_SCORE_EN is defined (DUT score width set to 4).
module tb_sc_level_tracker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       goalN;
    logic       clr;
    logic       abort;
    logic [4:0] progress;
    logic [2:0] level;
    logic       levelUp;
    logic       gameWon;
    logic [1:0] state;
`ifdef SC_LEVELTRACKER_SCORE_EN
    logic [3:0] score;
`endif

    int nChecks = 0;
    int nFails  = 0;

    sc_level_tracker #(
        .PROGRESS_WIDTH (5),
        .LEVEL_WIDTH    (3),
        .GOALS_PER_LEVEL(5),
        .NUM_LEVELS     (4),
        .SCORE_WIDTH    (4)
    ) dut (
        .SC_LEVELTRACKER_CLOCK_50        (clk),
        .SC_LEVELTRACKER_RESET_InHigh    (rst),
        .SC_LEVELTRACKER_Start_in        (start),
        .SC_LEVELTRACKER_Goal_InLow      (goalN),
        .SC_LEVELTRACKER_ClearProgress_in(clr),
        .SC_LEVELTRACKER_Abort_in        (abort),
        .SC_LEVELTRACKER_Progress_OutBus (progress),
        .SC_LEVELTRACKER_Level_OutBus    (level),
        .SC_LEVELTRACKER_LevelUp_out     (levelUp),
        .SC_LEVELTRACKER_GameWon_out     (gameWon),
        .SC_LEVELTRACKER_State_OutBus    (state)
`ifdef SC_LEVELTRACKER_SCORE_EN
        ,
        .SC_LEVELTRACKER_Score_OutBus    (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One separated goal: fall, then release.
    task automatic goalPulse();
        goalN = 1'b0;
        tick();
        goalN = 1'b1;
        tick();
    endtask

    task automatic startPulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nChecks++;
        if (state !== 2'b00 || progress !== 5'd0 || level !== 3'd0 || levelUp !== 1'b0 || gameWon !== 1'b0) begin
            nFails++;
            $display("FAIL reset: state=%b prog=%0d lvl=%0d up=%b won=%b, expected 00/0/0/0/0",
                     state, progress, level, levelUp, gameWon);
        end
        goalPulse();
        nChecks++;
        if (state !== 2'b00 || progress !== 5'd0) begin
            nFails++;
            $display("FAIL idle_goal: state=%b prog=%0d, expected 00/0", state, progress);
        end
    endtask

    task automatic test_level_up();
        startPulse();
        nChecks++;
        if (state !== 2'b01 || progress !== 5'd0 || level !== 3'd0) begin
            nFails++;
            $display("FAIL start: state=%b prog=%0d lvl=%0d, expected 01/0/0", state, progress, level);
        end
        for (int i = 1; i <= 4; i++) begin
            goalN = 1'b0;
            tick();
            nChecks++;
            if (progress !== 5'(i) || state !== 2'b01) begin
                nFails++;
                $display("FAIL goal_%0d: prog=%0d state=%b, expected %0d/01", i, progress, state, i);
            end
            goalN = 1'b1;
            tick();
        end
        goalN = 1'b0;
        tick();
        nChecks++;
        if (progress !== 5'd0 || state !== 2'b10 || levelUp !== 1'b1 || level !== 3'd0) begin
            nFails++;
            $display("FAIL level_done: prog=%0d state=%b up=%b lvl=%0d, expected 0/10/1/0",
                     progress, state, levelUp, level);
        end
        goalN = 1'b1;
        tick();
        nChecks++;
        if (state !== 2'b01 || levelUp !== 1'b0 || level !== 3'd1) begin
            nFails++;
            $display("FAIL level_next: state=%b up=%b lvl=%0d, expected 01/0/1", state, levelUp, level);
        end
    endtask

    task automatic test_held_low();
        goalN = 1'b0;
        repeat (10) tick();
        nChecks++;
        if (progress !== 5'd1) begin
            nFails++;
            $display("FAIL held_low: prog=%0d, expected 1", progress);
        end
        goalN = 1'b1;
        tick();
        nChecks++;
        if (progress !== 5'd1) begin
            nFails++;
            $display("FAIL held_release: prog=%0d, expected 1", progress);
        end
    endtask

    task automatic test_clear_same_cycle();
        goalPulse();
        goalPulse();
        nChecks++;
        if (progress !== 5'd3) begin
            nFails++;
            $display("FAIL pre_clear: prog=%0d, expected 3", progress);
        end
        goalN = 1'b0;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        goalN = 1'b1;
        nChecks++;
        if (progress !== 5'd0 || state !== 2'b01) begin
            nFails++;
            $display("FAIL clear_goal: prog=%0d state=%b, expected 0/01", progress, state);
        end
        tick();
        nChecks++;
        if (progress !== 5'd0) begin
            nFails++;
            $display("FAIL clear_after: prog=%0d, expected 0", progress);
        end
    endtask

    task automatic test_win();
        int ups;
        ups   = 0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        startPulse();
        for (int g = 0; g < 20; g++) begin
            goalN = 1'b0;
            tick();
            if (levelUp === 1'b1) ups++;
            goalN = 1'b1;
            tick();
            if (levelUp === 1'b1) ups++;
        end
        nChecks++;
        if (ups !== 4 || gameWon !== 1'b1 || level !== 3'd3 || state !== 2'b11 || progress !== 5'd0) begin
            nFails++;
            $display("FAIL win: ups=%0d won=%b lvl=%0d state=%b prog=%0d, expected 4/1/3/11/0",
                     ups, gameWon, level, state, progress);
        end
        goalPulse();
        nChecks++;
        if (progress !== 5'd0 || state !== 2'b11 || level !== 3'd3) begin
            nFails++;
            $display("FAIL won_goal: prog=%0d state=%b lvl=%0d, expected 0/11/3", progress, state, level);
        end
        startPulse();
        nChecks++;
        if (level !== 3'd0 || gameWon !== 1'b0 || state !== 2'b01) begin
            nFails++;
            $display("FAIL restart: lvl=%0d won=%b state=%b, expected 0/0/01", level, gameWon, state);
        end
    endtask

    task automatic test_abort_and_reset();
        repeat (14) goalPulse();
        nChecks++;
        if (level !== 3'd2 || progress !== 5'd4 || state !== 2'b01) begin
            nFails++;
            $display("FAIL pre_abort: lvl=%0d prog=%0d state=%b, expected 2/4/01", level, progress, state);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nChecks++;
        if (state !== 2'b00 || level !== 3'd0 || progress !== 5'd0) begin
            nFails++;
            $display("FAIL abort: state=%b lvl=%0d prog=%0d, expected 00/0/0", state, level, progress);
        end
        startPulse();
        repeat (4) goalPulse();
        goalN = 1'b0;
        tick();
        goalN = 1'b1;
        nChecks++;
        if (state !== 2'b10) begin
            nFails++;
            $display("FAIL pre_reset: state=%b, expected 10", state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nChecks++;
        if (state !== 2'b00 || levelUp !== 1'b0 || level !== 3'd0 || progress !== 5'd0 || gameWon !== 1'b0) begin
            nFails++;
            $display("FAIL reset_level_done: state=%b up=%b lvl=%0d prog=%0d won=%b, expected 00/0/0/0/0",
                     state, levelUp, level, progress, gameWon);
        end
    endtask

`ifdef SC_LEVELTRACKER_SCORE_EN
    task automatic test_score();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        startPulse();
        repeat (5) goalPulse();
        nChecks++;
        if (score !== 4'd5 || level !== 3'd1) begin
            nFails++;
            $display("FAIL score_l0: score=%0d lvl=%0d, expected 5/1", score, level);
        end
        repeat (2) goalPulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nChecks++;
        if (score !== 4'd9 || progress !== 5'd0) begin
            nFails++;
            $display("FAIL score_clear: score=%0d prog=%0d, expected 9/0", score, progress);
        end
        repeat (5) goalPulse();
        nChecks++;
        if (score !== 4'd15 || level !== 3'd2) begin
            nFails++;
            $display("FAIL score_sat: score=%0d lvl=%0d, expected 15/2", score, level);
        end
        goalPulse();
        nChecks++;
        if (score !== 4'd15 || progress !== 5'd1) begin
            nFails++;
            $display("FAIL score_hold: score=%0d prog=%0d, expected 15/1", score, progress);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        goalN = 1'b1;
        clr   = 1'b0;
        abort = 1'b0;
        test_reset();
        test_level_up();
        test_held_low();
        test_clear_same_cycle();
        test_win();
        test_abort_and_reset();
`ifdef SC_LEVELTRACKER_SCORE_EN
        test_score();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
